// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter: state encoding,
// even-parity calculation and parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Zero-extending a narrower word into this argument leaves its parity unchanged.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

  function automatic bit params_legal(input int dwidth, input int clks_per_bit,
                                      input int parity_en, input int stop_bits);
    return (dwidth >= 1) && (dwidth <= 64) && (clks_per_bit >= 2) &&
           ((parity_en == 0) || (parity_en == 1)) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit
// with bit_tick; a synchronous clear holds it at zero between frames.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic             bit_tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign bit_tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one word at a time from the byte FIFO and serialises it onto the UART line:
// start bit, LSB-first data, optional even parity, then one or two stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              fifo_en,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DWIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] PRE_TICK  = CNT_W'(CLKS_PER_BIT - 2);

  if (!params_legal(DWIDTH, CLKS_PER_BIT, PARITY_EN, STOP_BITS)) begin : g_bad_params
    $error("fifo_uart_tx: illegal parameter combination");
  end

  tx_state_t         state;
  logic [DWIDTH-1:0] shift_reg;
  logic [DWIDTH-1:0] shift_next;
  logic              parity_bit;
  logic [IDX_W-1:0]  bit_idx;
  logic              baud_clear;
  logic              bit_tick;
  logic [CNT_W-1:0]  baud_cnt;

  // The bit timer only runs while a bit is on the line, so START always gets a full period.
  assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);
  assign shift_next = shift_reg >> 1;
  assign fifo_en    = fifo_rd;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick),
    .count   (baud_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      fifo_rd    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      // done is registered one cycle early so it lands on the final stop-bit cycle.
      done    <= (state == STOP) && (bit_idx == LAST_STOP) && (baud_cnt == PRE_TICK);

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (en && !fifo_empty) begin
            state   <= FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shift_reg  <= fifo_data;
          parity_bit <= even_parity(64'(fifo_data));
          bit_idx    <= '0;
          tx         <= 1'b0;
          state      <= START;
        end

        START: begin
          if (bit_tick) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx        <= shift_next[0];
              shift_reg <= shift_next;
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= STOP;
          end
        end

        STOP: begin
          if (bit_tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
